// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: register id/data widths,
// the write-request record carried through the long-latency buffer, and the
// write-port source selector.
package reg_write_arbiter_pkg;

    localparam int REG_ID_W   = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ID_W-1:0]   reg_id_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef struct packed {
        reg_id_t   id;
        reg_data_t value;
    } wr_req_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_WB,
        SRC_BUF,
        SRC_LU
    } wr_src_e;

    // Register 0 is hard-wired, so an id of 0 never names a real destination.
    function automatic logic id_valid(reg_id_t id);
        return id != '0;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bundle of the arbiter's request, handshake, hazard-query and write-port
// signals. The slave modport is the arbiter's view; master is the pipeline side.
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wb_write_en;
    reg_id_t          wb_write_id;
    reg_data_t        wb_write_value;

    logic             lu_valid;
    reg_id_t          lu_write_id;
    reg_data_t        lu_write_value;
    logic             lu_ready;

    logic             issue_en;
    reg_id_t          issue_id;
    reg_id_t          query_rs_id;
    reg_id_t          query_rt_id;
    logic             stall_out;

    logic             control_reg_write;
    reg_id_t          control_write_id;
    reg_data_t        reg_write_value;
    logic [CNT_W-1:0] pending_count;

    modport master (
        output wb_write_en, wb_write_id, wb_write_value,
        output lu_valid, lu_write_id, lu_write_value,
        input  lu_ready,
        output issue_en, issue_id, query_rs_id, query_rt_id,
        input  stall_out,
        input  control_reg_write, control_write_id, reg_write_value, pending_count
    );

    modport slave (
        input  wb_write_en, wb_write_id, wb_write_value,
        input  lu_valid, lu_write_id, lu_write_value,
        output lu_ready,
        input  issue_en, issue_id, query_rs_id, query_rt_id,
        output stall_out,
        output control_reg_write, control_write_id, reg_write_value, pending_count
    );

endinterface

// File: rtl/reg_write_arbiter_wr_fifo.sv
// Small FIFO holding long-latency results that lost the write port.
// Storage is not reset; only the pointers and occupancy are.
module wr_fifo
    import reg_write_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  wr_req_t          push_data,
    input  logic             pop,
    output wr_req_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage: written on push, never cleared.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter. Each cycle one source wins the single
// write port (WB, then buffered LU result, then LU bypass); the winner is
// registered so the register file sees stable values at its negedge write.
// A 32-bit scoreboard tracks registers awaiting long-latency results and
// drives the decode stall.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clock,
    input  logic                reset_n,
    reg_write_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    wr_src_e          src;
    wr_req_t          grant_req;
    wr_req_t          lu_req;
    wr_req_t          fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             wb_req;
    logic             lu_ready;
    logic             lu_xfer;

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    logic      wr_vld_p1;
    reg_id_t   wr_id_p1;
    reg_data_t wr_value_p1;

    assign wb_req   = bus.wb_write_en && id_valid(bus.wb_write_id);
    assign lu_ready = reset_n && !fifo_full;
    assign lu_xfer  = bus.lu_valid && lu_ready;
    assign lu_req   = '{id: bus.lu_write_id, value: bus.lu_write_value};

    wr_fifo #(
        .DEPTH (DEPTH)
    ) u_wr_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (lu_req),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pick the write-port owner; an LU result that does not win is buffered.
    always_comb begin
        src       = SRC_NONE;
        grant_req = '0;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (wb_req) begin
            src       = SRC_WB;
            grant_req = '{id: bus.wb_write_id, value: bus.wb_write_value};
            fifo_push = lu_xfer;
        end else if (!fifo_empty) begin
            src       = SRC_BUF;
            grant_req = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = lu_xfer;
        end else if (lu_xfer) begin
            src       = SRC_LU;
            grant_req = lu_req;
        end
    end

    // Scoreboard next state: granted LU results clear, issues set, set wins.
    always_comb begin
        pending_d = pending_q;
        if (src == SRC_BUF || src == SRC_LU) begin
            pending_d[grant_req.id] = 1'b0;
        end
        if (bus.issue_en && id_valid(bus.issue_id)) begin
            pending_d[bus.issue_id] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Write-port stage p1: id/value hold when nothing is granted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_vld_p1   <= 1'b0;
            wr_id_p1    <= '0;
            wr_value_p1 <= '0;
        end else begin
            wr_vld_p1 <= (src != SRC_NONE);
            if (src != SRC_NONE) begin
                wr_id_p1    <= grant_req.id;
                wr_value_p1 <= grant_req.value;
            end
        end
    end

    assign bus.lu_ready          = lu_ready;
    assign bus.pending_count     = fifo_count;
    assign bus.control_reg_write = wr_vld_p1;
    assign bus.control_write_id  = wr_id_p1;
    assign bus.reg_write_value   = wr_value_p1;
    assign bus.stall_out = (pending_q[bus.query_rs_id] && id_valid(bus.query_rs_id)) ||
                           (pending_q[bus.query_rt_id] && id_valid(bus.query_rt_id));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with DEPTH = 2.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   total   = 0;
    int   passed  = 0;
    int   failed  = 0;

    always #5 clock = ~clock;

    reg_write_arbiter_if #(.DEPTH(2)) bus ();

    reg_write_arbiter #(
        .DEPTH (2)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] id, input logic [31:0] val);
        bus.wb_write_en    = en;
        bus.wb_write_id    = id;
        bus.wb_write_value = val;
    endtask

    task automatic set_lu(input logic v, input logic [4:0] id, input logic [31:0] val);
        bus.lu_valid       = v;
        bus.lu_write_id    = id;
        bus.lu_write_value = val;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [4:0] id,
                            input logic [31:0] val);
        check({tag, ".we"},  32'(bus.control_reg_write), 32'(en));
        check({tag, ".id"},  32'(bus.control_write_id),  32'(id));
        check({tag, ".val"}, bus.reg_write_value,        val);
    endtask

    initial begin
        set_wb(1'b0, 5'd0, 32'h0);
        set_lu(1'b0, 5'd0, 32'h0);
        bus.issue_en    = 1'b0;
        bus.issue_id    = 5'd0;
        bus.query_rs_id = 5'd0;
        bus.query_rt_id = 5'd0;

        // Reset state
        #3;
        check_wr("rst", 1'b0, 5'd0, 32'h0);
        check("rst.cnt",   32'(bus.pending_count), 32'd0);
        check("rst.ready", 32'(bus.lu_ready),      32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check("rel.ready", 32'(bus.lu_ready), 32'd1);

        // WB write, LU idle
        set_wb(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        check_wr("wb5", 1'b1, 5'd5, 32'hDEADBEEF);
        set_wb(1'b0, 5'd0, 32'h0);
        tick();
        check_wr("idle_hold", 1'b0, 5'd5, 32'hDEADBEEF);

        // WB with id 0 does not take the slot; LU bypasses
        set_wb(1'b1, 5'd0, 32'h55);
        set_lu(1'b1, 5'd3, 32'h33);
        tick();
        check_wr("wb0_lu3", 1'b1, 5'd3, 32'h33);
        check("wb0.cnt", 32'(bus.pending_count), 32'd0);
        set_wb(1'b0, 5'd0, 32'h0);

        // LU bypass into empty buffer
        set_lu(1'b1, 5'd9, 32'h1234);
        tick();
        check_wr("lu9", 1'b1, 5'd9, 32'h1234);
        check("lu9.cnt", 32'(bus.pending_count), 32'd0);
        set_lu(1'b0, 5'd0, 32'h0);

        // Issue id 11, watched by rs
        bus.issue_en    = 1'b1;
        bus.issue_id    = 5'd11;
        bus.query_rs_id = 5'd11;
        tick();
        bus.issue_en = 1'b0;
        check("iss11.stall", 32'(bus.stall_out), 32'd1);

        // WB busy 3 cycles, LU offers 10, 11, 12
        set_wb(1'b1, 5'd1, 32'h100);
        set_lu(1'b1, 5'd10, 32'hA);
        tick();
        check_wr("busyA", 1'b1, 5'd1, 32'h100);
        check("busyA.cnt", 32'(bus.pending_count), 32'd1);
        set_wb(1'b1, 5'd2, 32'h200);
        set_lu(1'b1, 5'd11, 32'hB);
        #1;
        check("busyB.ready", 32'(bus.lu_ready), 32'd1);
        tick();
        check("busyB.cnt", 32'(bus.pending_count), 32'd2);
        set_wb(1'b1, 5'd3, 32'h300);
        set_lu(1'b1, 5'd12, 32'hC);
        #1;
        check("busyC.ready", 32'(bus.lu_ready), 32'd0);
        tick();
        check_wr("busyC", 1'b1, 5'd3, 32'h300);
        check("busyC.cnt", 32'(bus.pending_count), 32'd2);
        set_wb(1'b0, 5'd0, 32'h0);
        #1;
        check("drainD.ready", 32'(bus.lu_ready), 32'd0);
        tick();
        check_wr("drainD", 1'b1, 5'd10, 32'hA);
        check("drainD.cnt", 32'(bus.pending_count), 32'd1);
        check("drainD.stall", 32'(bus.stall_out), 32'd1);
        tick();
        check_wr("drainE", 1'b1, 5'd11, 32'hB);
        check("drainE.cnt", 32'(bus.pending_count), 32'd1);
        check("drainE.stall", 32'(bus.stall_out), 32'd0);
        set_lu(1'b0, 5'd0, 32'h0);
        tick();
        check_wr("drainF", 1'b1, 5'd12, 32'hC);
        check("drainF.cnt", 32'(bus.pending_count), 32'd0);
        tick();
        check("drainG.we", 32'(bus.control_reg_write), 32'd0);

        // Scoreboard on id 7, WB write does not clear it
        bus.issue_en    = 1'b1;
        bus.issue_id    = 5'd7;
        bus.query_rs_id = 5'd7;
        tick();
        bus.issue_en = 1'b0;
        check("iss7.stall", 32'(bus.stall_out), 32'd1);
        set_wb(1'b1, 5'd7, 32'h77);
        tick();
        check_wr("wb7", 1'b1, 5'd7, 32'h77);
        check("wb7.stall", 32'(bus.stall_out), 32'd1);
        set_wb(1'b0, 5'd0, 32'h0);
        bus.query_rs_id = 5'd0;
        bus.query_rt_id = 5'd7;
        set_lu(1'b1, 5'd7, 32'h7777);
        #1;
        check("pre_lu7.stall", 32'(bus.stall_out), 32'd1);
        tick();
        check_wr("lu7", 1'b1, 5'd7, 32'h7777);
        check("lu7.stall", 32'(bus.stall_out), 32'd0);
        set_lu(1'b0, 5'd0, 32'h0);

        // Set and clear of id 7 on one edge: set wins
        bus.issue_en = 1'b1;
        bus.issue_id = 5'd7;
        tick();
        check("reiss7.stall", 32'(bus.stall_out), 32'd1);
        set_lu(1'b1, 5'd7, 32'h70);
        tick();
        check_wr("setwins", 1'b1, 5'd7, 32'h70);
        check("setwins.stall", 32'(bus.stall_out), 32'd1);
        bus.issue_en = 1'b0;
        set_lu(1'b1, 5'd7, 32'h71);
        tick();
        check("clr7.stall", 32'(bus.stall_out), 32'd0);
        set_lu(1'b0, 5'd0, 32'h0);

        // Two entries buffered, then reset pulse discards them
        bus.query_rt_id = 5'd0;
        bus.query_rs_id = 5'd8;
        bus.issue_en    = 1'b1;
        bus.issue_id    = 5'd8;
        set_wb(1'b1, 5'd1, 32'h1);
        set_lu(1'b1, 5'd20, 32'h20);
        tick();
        bus.issue_en = 1'b0;
        set_wb(1'b1, 5'd2, 32'h2);
        set_lu(1'b1, 5'd21, 32'h21);
        tick();
        check("pre_rst.cnt",   32'(bus.pending_count), 32'd2);
        check("pre_rst.stall", 32'(bus.stall_out),     32'd1);
        set_wb(1'b0, 5'd0, 32'h0);
        set_lu(1'b0, 5'd0, 32'h0);
        reset_n = 1'b0;
        #1;
        check_wr("midrst", 1'b0, 5'd0, 32'h0);
        check("midrst.cnt",   32'(bus.pending_count), 32'd0);
        check("midrst.ready", 32'(bus.lu_ready),      32'd0);
        check("midrst.stall", 32'(bus.stall_out),     32'd0);
        tick();
        reset_n = 1'b1;
        #1;
        check("rel2.ready", 32'(bus.lu_ready), 32'd1);
        tick();
        check_wr("post1", 1'b0, 5'd0, 32'h0);
        tick();
        check_wr("post2", 1'b0, 5'd0, 32'h0);
        check("post2.cnt", 32'(bus.pending_count), 32'd0);
        set_lu(1'b1, 5'd13, 32'h13);
        tick();
        check_wr("post_lu13", 1'b1, 5'd13, 32'h13);
        set_lu(1'b0, 5'd0, 32'h0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter: DEPTH, 2, entries in the long-latency pending buffer (power of two, 2..4).
REQ-002 clock  in  1  system clock; all state updates on posedge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 wb_write_en / wb_write_id / wb_write_value  in  1/5/32  pipeline writeback request; never back-pressured.
REQ-005 lu_valid / lu_write_id / lu_write_value  in  1/5/32  long-latency unit result offer.
REQ-006 lu_ready  out  1  buffer can accept an LU result this cycle.
REQ-007 issue_en / issue_id  in  1/5  decode reserves issue_id as the destination of a long-latency op.
REQ-008 query_rs_id / query_rt_id  in  5/5  decode source registers for hazard check.
REQ-009 stall_out  out  1  combinational hazard: a queried register has a pending long-latency write.
REQ-010 control_reg_write / control_write_id / reg_write_value  out  1/5/32  registered register-file write port.
REQ-011 pending_count  out  clog2(DEPTH)+1  buffer occupancy.

Function
REQ-012 Write-port outputs SHALL update only on posedge, so they are stable at the register file's negedge write.
REQ-013 Each posedge, the write port SHALL be given to exactly one source, priority: WB, then buffer head, then LU bypass.
REQ-014 A WB request with wb_write_id = 0 SHALL count as no request and SHALL NOT consume the write slot.
REQ-015 LU handshake: transfer occurs on posedge when lu_valid && lu_ready; lu_id/value SHALL be held while lu_valid && !lu_ready.
REQ-016 lu_ready SHALL equal (pending_count < DEPTH); a pop in the same cycle SHALL NOT make a full buffer ready.
REQ-017 Bypass: transferred LU result, no WB, buffer empty -> written directly next edge, not buffered (latency 1 cycle).
REQ-018 Otherwise a transferred LU result SHALL be appended to the buffer in FIFO order; push and pop in one cycle SHALL leave the count unchanged.
REQ-019 Buffer pointers SHALL wrap modulo DEPTH.
REQ-020 A cycle with no granted source SHALL drive control_reg_write = 0, holding id and value.
REQ-021 Scoreboard: 32 pending bits; issue_en with issue_id != 0 sets pending[issue_id].
REQ-022 pending[id] SHALL clear on the edge where an LU result with that id is granted the write port.
REQ-023 Set and clear of the same id on one edge: set wins.
REQ-024 A WB write to a pending register SHALL NOT clear its pending bit.
REQ-025 stall_out = (pending[rs] && rs != 0) || (pending[rt] && rt != 0), from current registered state only.
REQ-026 No starvation guarantee is required; the buffer drains in any cycle WB is idle.

Reset
REQ-027 While reset_n = 0: control_reg_write = 0, control_write_id = 0, reg_write_value = 0, pending bits = 0, buffer empty, pending_count = 0, lu_ready = 0.
REQ-028 Reset assertion mid-operation SHALL discard buffered LU results; lu_ready SHALL be 1 on the first edge after release.

Structure
REQ-029 Shared package: REG_ID_W = 5, REG_DATA_W = 32, NUM_REGS = 32, and the write-request record (id, value).
REQ-030 One sub-module: wr_fifo (parameterised DEPTH FIFO with count, full, empty); scoreboard and arbitration stay in reg_write_arbiter.

Verification
REQ-031 WB id 5 value 0xDEADBEEF, LU idle -> next edge control_reg_write=1, id 5, value 0xDEADBEEF.
REQ-032 LU id 9 value 0x1234 offered, no WB, empty buffer -> written next edge; pending_count stays 0.
REQ-033 WB busy 3 cycles, LU offers ids 10, 11, 12 -> lu_ready drops after 2 accepts; ids written 10 then 11 once WB idles; 12 accepted afterwards.
REQ-034 issue id 7, query_rs_id 7 -> stall_out=1 until the LU write of id 7 is granted, then 0; WB write to 7 meanwhile keeps stall_out=1.
REQ-035 issue id 7 on the same edge an LU write of 7 is granted -> pending[7] remains 1.
REQ-036 Two entries buffered, reset_n pulsed low -> outputs 0, pending_count 0, no later write of the discarded entries.
